gated_edge_counter: RTL
=======================

// Module: gated_edge_counter
// PURPOSE
//  Consumer of the frequency-counter timebase gate (one bit sliced from the free-running counter by div).
//  Counts rising edges of an asynchronous input during each gate-high window.
//  Delivers each completed window count on an AXI-Stream master, tagged with the div value in force.
//  Sits between the gate selector and the PS-side FIFO/DMA of the frequency counter project.
// PARAMETERS
//  COUNT_WIDTH  32  width of edge count and m_axis_tdata
//  DIV_WIDTH    5   width of div / m_axis_tuser
//  SYNC_STAGES  2   flip-flop stages on sig_in (>=2)
// PORTS
//  aclk           in   1            system clock, all logic rising-edge
//  aresetn        in   1            synchronous reset, active-low
//  gate           in   1            timebase gate, aclk domain, high = measurement window
//  div            in   DIV_WIDTH    gate divider setting, aclk domain
//  sig_in         in   1            measured signal, asynchronous
//  m_axis_tdata   out  COUNT_WIDTH  edges counted in last completed window
//  m_axis_tuser   out  DIV_WIDTH    div value for that window
//  m_axis_tvalid  out  1            result valid
//  m_axis_tready  in   1            downstream accept
//  overrun        out  1            sticky: a completed window was dropped
// BEHAVIOUR
//  Clock is aclk; reset is synchronous and active-low on aresetn.
//  Reset: all sync FFs, gate_q, div_q, count = 0.
//  Reset: state = ARM; m_axis_tdata/tuser = 0; m_axis_tvalid = 0; overrun = 0.
//  Input path: sig_in -> SYNC_STAGES FFs -> s_q.
//  edge = s_sync & ~s_q; counted edge lags sig_in by SYNC_STAGES+1 cycles.
//  gate_q = gate registered.
//  rise = gate & ~gate_q; fall = ~gate & gate_q.
//  State machine:
//   ARM: count held 0; ignores edges; a window already open at reset/abort is never measured.
//        On rise -> COUNT, count <= 0, div_q <= div.
//   COUNT: edge=1 -> count += 1, saturating at all-ones (no wrap).
//          On fall -> capture, then go to ARM.
//          On div != div_q -> abort: count discarded, no output, go to ARM.
//  Capture: final value includes an edge coinciding with the fall cycle.
//  Capture latency: m_axis_tvalid asserts the cycle after the fall cycle.
//  Capture data: tdata = final count, tuser = div_q.
//  Output register handshake:
//   tvalid/tdata/tuser stay stable until tvalid & tready.
//   The transfer cycle clears tvalid unless a capture occurs in the same cycle; then the new result loads and tvalid stays 1.
//   Capture while tvalid=1 and tready=0: new result dropped, old result kept, overrun <= 1.
//   overrun clears only on reset.
//  Simultaneous: abort (div change) takes priority over fall in the same cycle.
//  rise in ARM and fall can't coincide (gate_q gating), so back-to-back windows are unaffected.
//  Reset mid-window or mid-handshake: everything returns to reset values next cycle; pending result lost.
// TESTING
//  1. gate 16 clk high / 16 low, sig_in toggles every 2 clk -> each result tdata=4, tuser=div, tvalid 1 clk after fall.
//  2. Reset released with gate already high -> no output until after the first full window; first result equals that window's true count.
//  3. COUNT_WIDTH=4, 20 edges in one window -> tdata=15 (saturated), next window counts from 0.
//  4. tready=0 across two windows -> first result held unchanged, overrun=1; after tready=1 the first result transfers, tvalid then drops.
//  5. div changed 3 -> 4 mid-window -> no output for that window; next full window output has tuser=4.
//  6. tready=1 permanently, windows 1 clk apart in the low phase -> every window delivered, overrun stays 0.

Source files
------------

// File: rtl/gated_edge_counter.sv
// Counts synchronised rising edges of sig_in inside each gate-high window
// and presents every completed count on an AXI-Stream master tagged with div.
module gated_edge_counter #(
    parameter int COUNT_WIDTH = 32,
    parameter int DIV_WIDTH   = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   gate,
    input  logic [DIV_WIDTH-1:0]   div,
    input  logic                   sig_in,
    output logic [COUNT_WIDTH-1:0] m_axis_tdata,
    output logic [DIV_WIDTH-1:0]   m_axis_tuser,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   overrun
);

    typedef enum logic {ARM, COUNT} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_q;
    logic                   r_gate_q;
    logic                   r_gate_vld;
    logic [DIV_WIDTH-1:0]   r_div_q;
    logic [DIV_WIDTH-1:0]   w_div_q_nxt;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_nxt;
    logic [COUNT_WIDTH-1:0] w_count_inc;
    logic [COUNT_WIDTH-1:0] w_count_upd;
    logic                   w_s_sync;
    logic                   w_edge;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_abort;
    logic                   w_cap;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_sync     <= '0;
            r_s_q      <= 1'b0;
            r_gate_q   <= 1'b0;
            r_gate_vld <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_s_q      <= w_s_sync;
            r_gate_q   <= gate;
            r_gate_vld <= 1'b1;
        end
    end

    assign w_s_sync = r_sync[SYNC_STAGES-1];
    assign w_edge   = w_s_sync & ~r_s_q;
    // gate_q is not a real sample in the first cycle after reset, so a
    // window already open then must not look like a rise
    assign w_rise   = gate & ~r_gate_q & r_gate_vld;
    assign w_fall   = ~gate & r_gate_q;
    assign w_abort  = (div != r_div_q);

    assign w_count_inc = (r_count == '1) ? r_count
                                         : r_count + COUNT_WIDTH'(1);
    assign w_count_upd = w_edge ? w_count_inc : r_count;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_div_q_nxt = r_div_q;
        w_cap       = 1'b0;
        unique case (r_state)
            ARM: begin
                w_count_nxt = '0;
                if (w_rise) begin
                    w_state_nxt = COUNT;
                    w_div_q_nxt = div;
                end
            end
            COUNT: begin
                if (w_abort) begin
                    w_state_nxt = ARM;
                    w_count_nxt = '0;
                end else if (w_fall) begin
                    w_cap       = 1'b1;
                    w_state_nxt = ARM;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = w_count_upd;
                end
            end
            default: w_state_nxt = ARM;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= ARM;
            r_count <= '0;
            r_div_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_div_q <= w_div_q_nxt;
        end
    end

    // a capture may reuse the slot freed by a transfer in the same cycle
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
            overrun       <= 1'b0;
        end else if (w_cap) begin
            if (!m_axis_tvalid || m_axis_tready) begin
                m_axis_tdata  <= w_count_upd;
                m_axis_tuser  <= r_div_q;
                m_axis_tvalid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule
